beamformer_sequencer: RTL and testbench

- Control FSM that runs one complete pass of the BRAM delay-and-sum beamformer.
- Drives the input-RAM read address and enable, the slice_state select, the sample_index counter and the startbeamformer gate, in that order per pass.
- Waits for the beamformer pipeline to drain, then reads the output RAM out to a downstream consumer using a ready handshake.
- Sits between the top-level capture/UART control and the beamformer datapath.

---
 rtl/beamformer_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_beamformer_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beamformer_sequencer.sv
// Beamformer pass sequencer: prime, feed (address, slice) pairs, drain the pipeline, read results out.
// Optional macro BFSEQ_LOOP_EN adds i_loop_mode so DONE restarts the next pass without returning to IDLE.
module beamformer_sequencer #(
    parameter int unsigned NUM_SAMPLES  = 2048,
    parameter int unsigned NUM_SLICES   = 3,
    parameter int unsigned DRAIN_CYCLES = 64,
    parameter int unsigned ADDR_W       = 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef BFSEQ_LOOP_EN
    input  logic              i_loop_mode,
`endif
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_usedataflag,
    input  logic              i_readout_ready,
    output logic [ADDR_W-1:0] o_readin_address,
    output logic              o_readinen,
    output logic [1:0]        o_slice_state,
    output logic [15:0]       o_sample_index,
    output logic              o_startbeamformer,
    output logic [ADDR_W-1:0] o_sumout_address,
    output logic              o_sumouten,
    output logic              o_out_valid,
    output logic [ADDR_W:0]   o_wr_count,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned      CNT_W  = ADDR_W + 1;
    localparam int unsigned      DRN_W  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(NUM_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_FEED,
        S_DRAIN,
        S_READOUT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            r_state,            w_nxt_state;
    logic [ADDR_W-1:0] r_readin_address,   w_nxt_readin_address;
    logic              r_readinen,         w_nxt_readinen;
    logic [1:0]        r_slice_state,      w_nxt_slice_state;
    logic [15:0]       r_sample_index,     w_nxt_sample_index;
    logic              r_startbeamformer,  w_nxt_startbeamformer;
    logic [ADDR_W-1:0] r_sumout_address,   w_nxt_sumout_address;
    logic              r_sumouten,         w_nxt_sumouten;
    logic              r_out_valid,        w_nxt_out_valid;
    logic [CNT_W-1:0]  r_wr_count,         w_nxt_wr_count;
    logic              r_busy,             w_nxt_busy;
    logic              r_done,             w_nxt_done;
    logic [DRN_W-1:0]  r_drain_cnt,        w_nxt_drain_cnt;
    logic [CNT_W-1:0]  r_rd_cnt,           w_nxt_rd_cnt;

    logic              w_loop;
    logic              w_go_prime;
    logic              w_go_idle;
    logic [CNT_W-1:0]  w_wr_inc;
    logic [CNT_W-1:0]  w_rd_lim;
    logic [DRN_W-1:0]  w_drain_inc;

`ifdef BFSEQ_LOOP_EN
    assign w_loop = i_loop_mode;
`else
    assign w_loop = 1'b0;
`endif

    // Saturating write count and number of output words that actually exist in the RAM
    assign w_wr_inc    = (r_wr_count == WR_MAX) ? r_wr_count : r_wr_count + CNT_W'(1);
    assign w_rd_lim    = (r_wr_count < RD_MAX) ? r_wr_count : RD_MAX;
    assign w_drain_inc = r_drain_cnt + DRN_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state           <= S_IDLE;
            r_readin_address  <= '0;
            r_readinen        <= 1'b0;
            r_slice_state     <= 2'd0;
            r_sample_index    <= 16'hFFFF;
            r_startbeamformer <= 1'b0;
            r_sumout_address  <= '0;
            r_sumouten        <= 1'b0;
            r_out_valid       <= 1'b0;
            r_wr_count        <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_drain_cnt       <= '0;
            r_rd_cnt          <= '0;
        end else begin
            r_state           <= w_nxt_state;
            r_readin_address  <= w_nxt_readin_address;
            r_readinen        <= w_nxt_readinen;
            r_slice_state     <= w_nxt_slice_state;
            r_sample_index    <= w_nxt_sample_index;
            r_startbeamformer <= w_nxt_startbeamformer;
            r_sumout_address  <= w_nxt_sumout_address;
            r_sumouten        <= w_nxt_sumouten;
            r_out_valid       <= w_nxt_out_valid;
            r_wr_count        <= w_nxt_wr_count;
            r_busy            <= w_nxt_busy;
            r_done            <= w_nxt_done;
            r_drain_cnt       <= w_nxt_drain_cnt;
            r_rd_cnt          <= w_nxt_rd_cnt;
        end
    end

    // Next state and next registered outputs; abort overrides everything at the end
    always_comb begin
        w_nxt_state           = r_state;
        w_nxt_readin_address  = r_readin_address;
        w_nxt_readinen        = r_readinen;
        w_nxt_slice_state     = r_slice_state;
        w_nxt_sample_index    = r_sample_index;
        w_nxt_startbeamformer = r_startbeamformer;
        w_nxt_sumout_address  = r_sumout_address;
        w_nxt_sumouten        = 1'b0;
        w_nxt_out_valid       = r_sumouten;
        w_nxt_wr_count        = r_wr_count;
        w_nxt_busy            = r_busy;
        w_nxt_done            = 1'b0;
        w_nxt_drain_cnt       = r_drain_cnt;
        w_nxt_rd_cnt          = r_rd_cnt;
        w_go_prime            = 1'b0;
        w_go_idle             = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_go_prime = 1'b1;
                end
            end
            S_PRIME: begin
                w_nxt_state          = S_FEED;
                w_nxt_readin_address = '0;
                w_nxt_slice_state    = 2'd1;
                w_nxt_sample_index   = r_sample_index + 16'd1;
            end
            S_FEED: begin
                if (i_usedataflag) begin
                    w_nxt_wr_count = w_wr_inc;
                end
                if (r_slice_state == 2'(NUM_SLICES)) begin
                    if (r_readin_address == ADDR_W'(NUM_SAMPLES - 1)) begin
                        w_nxt_state       = S_DRAIN;
                        w_nxt_readinen    = 1'b0;
                        w_nxt_slice_state = 2'd0;
                        w_nxt_drain_cnt   = '0;
                    end else begin
                        w_nxt_slice_state    = 2'd1;
                        w_nxt_readin_address = r_readin_address + ADDR_W'(1);
                        w_nxt_sample_index   = r_sample_index + 16'd1;
                    end
                end else begin
                    w_nxt_slice_state  = r_slice_state + 2'd1;
                    w_nxt_sample_index = r_sample_index + 16'd1;
                end
            end
            S_DRAIN: begin
                if (i_usedataflag) begin
                    w_nxt_drain_cnt = '0;
                    w_nxt_wr_count  = w_wr_inc;
                end else if (w_drain_inc == DRN_W'(DRAIN_CYCLES)) begin
                    w_nxt_startbeamformer = 1'b0;
                    w_nxt_rd_cnt          = '0;
                    if (r_wr_count == '0) begin
                        w_nxt_state = S_DONE;
                        w_nxt_done  = 1'b1;
                    end else begin
                        w_nxt_state = S_READOUT;
                    end
                end else begin
                    w_nxt_drain_cnt = w_drain_inc;
                end
            end
            S_READOUT: begin
                // Leave once the final read is on the RAM port so its out_valid lands in FLUSH
                if (r_rd_cnt == w_rd_lim) begin
                    w_nxt_state = S_FLUSH;
                end else if (i_readout_ready) begin
                    w_nxt_sumouten       = 1'b1;
                    w_nxt_sumout_address = r_rd_cnt[ADDR_W-1:0];
                    w_nxt_rd_cnt         = r_rd_cnt + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                w_nxt_state = S_DONE;
                w_nxt_done  = 1'b1;
            end
            S_DONE: begin
                if (w_loop) begin
                    w_go_prime = 1'b1;
                end else begin
                    w_go_idle = 1'b1;
                end
            end
            default: begin
                w_go_idle = 1'b1;
            end
        endcase

        if (w_go_prime) begin
            w_nxt_state           = S_PRIME;
            w_nxt_readin_address  = '0;
            w_nxt_readinen        = 1'b1;
            w_nxt_slice_state     = 2'd0;
            w_nxt_sample_index    = 16'hFFFF;
            w_nxt_startbeamformer = 1'b1;
            w_nxt_sumout_address  = '0;
            w_nxt_wr_count        = '0;
            w_nxt_busy            = 1'b1;
            w_nxt_drain_cnt       = '0;
            w_nxt_rd_cnt          = '0;
        end

        if (w_go_idle || i_abort) begin
            w_nxt_state           = S_IDLE;
            w_nxt_readin_address  = '0;
            w_nxt_readinen        = 1'b0;
            w_nxt_slice_state     = 2'd0;
            w_nxt_sample_index    = 16'hFFFF;
            w_nxt_startbeamformer = 1'b0;
            w_nxt_sumout_address  = '0;
            w_nxt_sumouten        = 1'b0;
            w_nxt_out_valid       = 1'b0;
            w_nxt_wr_count        = '0;
            w_nxt_busy            = 1'b0;
            w_nxt_done            = 1'b0;
            w_nxt_drain_cnt       = '0;
            w_nxt_rd_cnt          = '0;
        end
    end

    assign o_readin_address  = r_readin_address;
    assign o_readinen        = r_readinen;
    assign o_slice_state     = r_slice_state;
    assign o_sample_index    = r_sample_index;
    assign o_startbeamformer = r_startbeamformer;
    assign o_sumout_address  = r_sumout_address;
    assign o_sumouten        = r_sumouten;
    assign o_out_valid       = r_out_valid;
    assign o_wr_count        = r_wr_count;
    assign o_busy            = r_busy;
    assign o_done            = r_done;

endmodule

// File: tb/tb_beamformer_sequencer.sv
// Self-checking bench for beamformer_sequencer: vector table, pass-level reference model, directed corner cases.
module tb_beamformer_sequencer;

    localparam int unsigned NS     = 4;
    localparam int unsigned SL     = 3;
    localparam int unsigned DC     = 4;
    localparam int unsigned AW     = 11;
    localparam int          FEED_N = NS * SL;
    localparam int          D0     = 2 + FEED_N;
    localparam int          MAXC   = 128;

    typedef struct packed {
        logic [AW-1:0] ra;
        logic          ren;
        logic [1:0]    sl;
        logic [15:0]   si;
        logic          sb;
        logic [AW-1:0] sa;
        logic          soe;
        logic          ov;
        logic [AW:0]   wc;
        logic          busy;
        logic          done;
    } outs_t;

    typedef struct {
        logic  start;
        logic  abort;
        logic  ud;
        logic  rr;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, abort, ud, rr;
`ifdef BFSEQ_LOOP_EN
    logic loop_mode;
`endif
    logic [AW-1:0] readin_address, sumout_address;
    logic          readinen, startbeamformer, sumouten, out_valid, busy, done;
    logic [1:0]    slice_state;
    logic [15:0]   sample_index;
    logic [AW:0]   wr_count;

    int n_chk = 0;
    int n_err = 0;

    logic  ud_v  [MAXC];
    logic  rr_v  [MAXC];
    outs_t exp_v [MAXC];
    int    end_t;
    vec_t  tbl   [19];

    always #5 clk = ~clk;

    beamformer_sequencer #(
        .NUM_SAMPLES (NS),
        .NUM_SLICES  (SL),
        .DRAIN_CYCLES(DC),
        .ADDR_W      (AW)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
`ifdef BFSEQ_LOOP_EN
        .i_loop_mode      (loop_mode),
`endif
        .i_start          (start),
        .i_abort          (abort),
        .i_usedataflag    (ud),
        .i_readout_ready  (rr),
        .o_readin_address (readin_address),
        .o_readinen       (readinen),
        .o_slice_state    (slice_state),
        .o_sample_index   (sample_index),
        .o_startbeamformer(startbeamformer),
        .o_sumout_address (sumout_address),
        .o_sumouten       (sumouten),
        .o_out_valid      (out_valid),
        .o_wr_count       (wr_count),
        .o_busy           (busy),
        .o_done           (done)
    );

    function automatic outs_t mk(input int ren, input int ra, input int sl, input int si,
                                 input int sb, input int soe, input int sa, input int ov,
                                 input int wc, input int bz, input int dn);
        outs_t o;
        o.ren  = 1'(ren);
        o.ra   = AW'(ra);
        o.sl   = 2'(sl);
        o.si   = 16'(si);
        o.sb   = 1'(sb);
        o.soe  = 1'(soe);
        o.sa   = AW'(sa);
        o.ov   = 1'(ov);
        o.wc   = (AW+1)'(wc);
        o.busy = 1'(bz);
        o.done = 1'(dn);
        return o;
    endfunction

    // Addresses are don't-care while their enable is low
    function automatic outs_t mask(input outs_t o);
        outs_t m = o;
        if (!m.ren) m.ra = '0;
        if (!m.soe) m.sa = '0;
        return m;
    endfunction

    function automatic outs_t sample_dut();
        outs_t o;
        o.ra = readin_address;  o.ren = readinen;  o.sl = slice_state;  o.si = sample_index;
        o.sb = startbeamformer; o.sa = sumout_address; o.soe = sumouten; o.ov = out_valid;
        o.wc = wr_count;        o.busy = busy;     o.done = done;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t exp);
        outs_t act = mask(sample_dut());
        outs_t e   = mask(exp);
        n_chk++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got ra=%0d ren=%0d sl=%0d si=%0d sb=%0d sa=%0d soe=%0d ov=%0d wc=%0d busy=%0d done=%0d | want ra=%0d ren=%0d sl=%0d si=%0d sb=%0d sa=%0d soe=%0d ov=%0d wc=%0d busy=%0d done=%0d",
                     name, act.ra, act.ren, act.sl, act.si, act.sb, act.sa, act.soe, act.ov, act.wc, act.busy, act.done,
                     e.ra, e.ren, e.sl, e.si, e.sb, e.sa, e.soe, e.ov, e.wc, e.busy, e.done);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pass-level model: cycle 0 is the IDLE cycle carrying start, cycle 1 is PRIME
    task automatic build_expected();
        int t, w, run, lim, issued, cur_sa;
        logic cur_soe, prev_soe;
        for (int i = 0; i < MAXC; i++) exp_v[i] = mk(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        exp_v[1] = mk(1, 0, 0, 16'hFFFF, 1, 0, 0, 0, 0, 1, 0);
        w = 0;
        for (int k = 0; k < FEED_N; k++) begin
            exp_v[2 + k] = mk(1, k / SL, (k % SL) + 1, k, 1, 0, 0, 0, w, 1, 0);
            if (ud_v[2 + k]) w++;
        end
        t = D0;
        run = 0;
        while (run < DC) begin
            exp_v[t] = mk(0, 0, 0, FEED_N - 1, 1, 0, 0, 0, w, 1, 0);
            if (ud_v[t]) begin
                w++;
                run = 0;
            end else begin
                run++;
            end
            t++;
        end
        if (w > 2048) w = 2048;
        lim = (w < NS) ? w : NS;
        if (w != 0) begin
            issued = 0; cur_soe = 1'b0; cur_sa = 0; prev_soe = 1'b0;
            forever begin
                exp_v[t] = mk(0, 0, 0, FEED_N - 1, 0, cur_soe, cur_sa, prev_soe, w, 1, 0);
                prev_soe = cur_soe;
                if (issued == lim) break;
                if (rr_v[t]) begin
                    cur_soe = 1'b1;
                    cur_sa  = issued;
                    issued++;
                end else begin
                    cur_soe = 1'b0;
                end
                t++;
            end
            t++;
            exp_v[t] = mk(0, 0, 0, FEED_N - 1, 0, 0, 0, 1, w, 1, 0);
            t++;
        end
        exp_v[t] = mk(0, 0, 0, FEED_N - 1, 0, 0, 0, 0, w, 1, 1);
        end_t = t + 1;
    endtask

    task automatic run_pass(input string name, input bit rand_start);
        build_expected();
        for (int t = 0; t <= end_t; t++) begin
            start = (t == 0) || (rand_start && t < end_t && $urandom_range(0, 7) == 0);
            ud    = ud_v[t];
            rr    = rr_v[t];
            check_outs($sformatf("%s_t%0d", name, t), exp_v[t]);
            tick();
        end
        start = 1'b0;
        ud    = 1'b0;
    endtask

    task automatic fill_plain();
        for (int t = 0; t < MAXC; t++) begin
            ud_v[t] = 1'b0;
            rr_v[t] = 1'b1;
        end
    endtask

    task automatic fill_random();
        for (int t = 0; t < MAXC; t++) begin
            ud_v[t] = (t < D0 + 24) && ($urandom_range(0, 2) == 0);
            rr_v[t] = (t > 90) || ($urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic rr_pat [6];
        int   ndone;
        logic busy_gap;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ud = 1'b0; rr = 1'b1;
`ifdef BFSEQ_LOOP_EN
        loop_mode = 1'b0;
`endif

        // Scenario 1 and 4 as a cycle table: feed sequence then a pass with no writes
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 16'hFFFF, 1, 0, 0, 0, 0, 1, 0)};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 1,  0, 1, 0, 0, 0, 0, 1, 0)};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 2,  1, 1, 0, 0, 0, 0, 1, 0)};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 3,  2, 1, 0, 0, 0, 0, 1, 0)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 1, 1,  3, 1, 0, 0, 0, 0, 1, 0)};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 1, 2,  4, 1, 0, 0, 0, 0, 1, 0)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 1, 3,  5, 1, 0, 0, 0, 0, 1, 0)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 2, 1,  6, 1, 0, 0, 0, 0, 1, 0)};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 2, 2,  7, 1, 0, 0, 0, 0, 1, 0)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 2, 3,  8, 1, 0, 0, 0, 0, 1, 0)};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 3, 1,  9, 1, 0, 0, 0, 0, 1, 0)};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 3, 2, 10, 1, 0, 0, 0, 0, 1, 0)};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 3, 3, 11, 1, 0, 0, 0, 0, 1, 0)};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 11, 1, 0, 0, 0, 0, 1, 0)};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 11, 1, 0, 0, 0, 0, 1, 0)};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 11, 1, 0, 0, 0, 0, 1, 0)};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 11, 1, 0, 0, 0, 0, 1, 0)};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 11, 0, 0, 0, 0, 0, 1, 1)};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0)};

        repeat (3) tick();
        check_outs("reset", mk(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        tick();
        check_outs("idle", mk(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 19; i++) begin
            start = tbl[i].start;
            abort = tbl[i].abort;
            ud    = tbl[i].ud;
            rr    = tbl[i].rr;
            tick();
            check_outs($sformatf("tbl%0d", i), tbl[i].exp);
        end
        start = 1'b0;

        // Scenario 2: four writes in DRAIN, ready held high
        fill_plain();
        for (int k = 0; k < 4; k++) ud_v[D0 + k] = 1'b1;
        run_pass("s2", 1'b0);

        // Scenario 3: ready pattern 1,0,0,1,1,1 from the first READOUT cycle
        fill_plain();
        for (int k = 0; k < 4; k++) ud_v[D0 + k] = 1'b1;
        rr_pat[0] = 1'b1; rr_pat[1] = 1'b0; rr_pat[2] = 1'b0;
        rr_pat[3] = 1'b1; rr_pat[4] = 1'b1; rr_pat[5] = 1'b1;
        for (int k = 0; k < 6; k++) rr_v[D0 + 8 + k] = rr_pat[k];
        run_pass("s3", 1'b0);

        // More writes than RAM words: readout is clipped to NUM_SAMPLES
        fill_plain();
        for (int t = 5; t < D0 + 3; t++) ud_v[t] = 1'b1;
        run_pass("clip", 1'b0);

        // Scenario 5: abort on the 5th FEED cycle, then a clean pass
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check_outs("s5_feed5", mk(1, 1, 2, 4, 1, 0, 0, 0, 0, 1, 0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_outs($sformatf("s5_idle%0d", i), mk(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));
            tick();
        end
        fill_random();
        run_pass("s5_after", 1'b0);

        // Reset in the middle of DRAIN behaves like abort
        start = 1'b1;
        tick();
        start = 1'b0;
        ud = 1'b1;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ud  = 1'b0;
        check_outs("rst_mid", mk(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));
        tick();
        check_outs("rst_mid_idle", mk(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));

        // Scenario 6: start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_outs("s6_abort_wins", mk(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));
        tick();
        check_outs("s6_still_idle", mk(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));

        // Randomized passes with stray start pulses while busy
        for (int p = 0; p < 16; p++) begin
            fill_random();
            run_pass($sformatf("rnd%0d", p), 1'b1);
        end

`ifdef BFSEQ_LOOP_EN
        // Loop mode: two back-to-back passes, busy never drops between them
        ud = 1'b0;
        rr = 1'b1;
        loop_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        busy_gap = 1'b0;
        for (int c = 0; c < 80 && ndone < 2; c++) begin
            if (done) ndone++;
            else if (ndone == 1) loop_mode = 1'b0;
            if (!busy) busy_gap = 1'b1;
            tick();
        end
        check_val("loop_done_pulses", ndone, 2);
        check_val("loop_busy_gap", int'(busy_gap), 0);
        check_val("loop_exit_busy", int'(busy), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
